// File: rtl/result_display_converter.sv
// rtl/result_display_converter.sv - 8-bit result to BCD (double dabble) and 3-digit seven-segment display; optional NEG_SIGN_EN
module result_display_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  input  logic                add_sub_ovf,
  input  logic [1:0]          mult_div_ovf,
`ifdef NEG_SIGN_EN
  input  logic                signed_mode,
  output logic [7:0]          hex3,
`endif
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic [7:0]          hex0,
  output logic [7:0]          hex1,
  output logic [7:0]          hex2
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t              state, state_next;
  logic                load, shift_en, finish;
  logic [CW-1:0]       count;
  logic [WIDTH-1:0]    bin_q, load_bin;
  logic [4*DIGITS-1:0] acc_q, acc_adj;
  logic                asf_q;
  logic [1:0]          mdf_q;
  logic [3:0]          hund, tens, ones;
  logic [7:0]          seg_h, seg_t, seg_o;

  // active-low segment pattern {dp,g,f,e,d,c,b,a} for a decimal digit, dp off
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

`ifdef NEG_SIGN_EN
  logic neg_q, take_neg;
  assign take_neg = signed_mode & value[WIDTH-1];
  // a negative signed result is converted as its magnitude; 8'h80 becomes 128
  assign load_bin = take_neg ? (~value + WIDTH'(1)) : value;
`else
  assign load_bin = value;
`endif

  assign busy = (state != IDLE);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state and datapath strobes
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (start) begin
        load       = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (count == CW'(1)) state_next = FINISH;
      end
      FINISH: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // double-dabble correction: every nibble >= 5 gets +3 before the shift
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  assign hund  = acc_q[8 +: 4];
  assign tens  = acc_q[4 +: 4];
  assign ones  = acc_q[0 +: 4];
  assign seg_h = seg7(hund);
  assign seg_t = seg7(tens);
  assign seg_o = seg7(ones);

  // conversion registers and display outputs; outputs only change at FINISH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      bin_q <= '0;
      acc_q <= '0;
      asf_q <= 1'b0;
      mdf_q <= 2'b00;
      done  <= 1'b0;
      bcd   <= '0;
      hex0  <= 8'hFF;
      hex1  <= 8'hFF;
      hex2  <= 8'hFF;
`ifdef NEG_SIGN_EN
      neg_q <= 1'b0;
      hex3  <= 8'hFF;
`endif
    end else begin
      done <= finish;
      if (load) begin
        count <= CW'(WIDTH);
        bin_q <= load_bin;
        acc_q <= '0;
        asf_q <= add_sub_ovf;
        mdf_q <= mult_div_ovf;
`ifdef NEG_SIGN_EN
        neg_q <= take_neg;
`endif
      end
      if (shift_en) begin
        acc_q <= {acc_adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
        bin_q <= {bin_q[WIDTH-2:0], 1'b0};
        count <= count - CW'(1);
      end
      if (finish) begin
        bcd  <= acc_q;
        hex0 <= {~asf_q, seg_o[6:0]};
        hex1 <= {~mdf_q[0], ((hund == 4'd0) && (tens == 4'd0)) ? 7'h7F : seg_t[6:0]};
        hex2 <= {~mdf_q[1], (hund == 4'd0) ? 7'h7F : seg_h[6:0]};
`ifdef NEG_SIGN_EN
        hex3 <= neg_q ? 8'hBF : 8'hFF;
`endif
      end
    end
  end

endmodule
